// File: rtl/cart_load_seq.sv
// Cartridge load sequencer: copies a download into cart memory, pads the rest with FILL_BYTE,
// derives the read mirror mask and holds the console in reset until the image is complete.
module cart_load_seq #(
    parameter int         HOLD_CYCLES = 1024,
    parameter logic [7:0] FILL_BYTE   = 8'hFF
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        dl_active,
    input  logic        dl_wr,
    input  logic [24:0] dl_addr,
    input  logic [7:0]  dl_data,
    input  logic [14:0] cart_a_i,
    output logic [14:0] cart_a_o,
    output logic        mem_we,
    output logic [14:0] mem_addr,
    output logic [7:0]  mem_din,
    output logic        core_reset,
    output logic        busy,
    output logic [15:0] cart_size,
    output logic        overflow
);

    localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    typedef enum logic [1:0] {
        S_HOLD,
        S_RUN,
        S_LOAD,
        S_FILL
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          load_we_q, load_we_d;
    logic [14:0]   load_addr_q, load_addr_d;
    logic [7:0]    load_din_q, load_din_d;
    logic [14:0]   fill_addr_q, fill_addr_d;
    logic [15:0]   cart_size_q, cart_size_d;
    logic          overflow_q, overflow_d;
    logic [14:0]   mask_q, mask_d;

    logic          wr_ok;
    logic [15:0]   addr_p1;
    logic [15:0]   size_new;
    logic          fill_we;

    // Download writes are registered (latency 1); a write still in flight on the first FILL
    // cycle takes the port for that cycle and the fill pointer waits.
    assign wr_ok    = dl_wr && (dl_addr[24:15] == 10'd0);
    assign addr_p1  = {1'b0, dl_addr[14:0]} + 16'd1;
    assign size_new = (wr_ok && (addr_p1 > cart_size_q)) ? addr_p1 : cart_size_q;
    assign fill_we  = (state_q == S_FILL) && !load_we_q;

    // NOTE: every _d gets a default before the case so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        load_we_d   = 1'b0;
        load_addr_d = load_addr_q;
        load_din_d  = load_din_q;
        fill_addr_d = fill_addr_q;
        cart_size_d = cart_size_q;
        overflow_d  = overflow_q;
        mask_d      = mask_q;

        case (state_q)
            S_HOLD: begin
                if (dl_active) begin
                    state_d     = S_LOAD;
                    cart_size_d = 16'd0;
                    overflow_d  = 1'b0;
                end else if (cnt_q == CW'(HOLD_CYCLES - 1)) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RUN: begin
                if (dl_active) begin
                    state_d     = S_LOAD;
                    cart_size_d = 16'd0;
                    overflow_d  = 1'b0;
                end
            end
            S_LOAD: begin
                if (wr_ok) begin
                    load_we_d   = 1'b1;
                    load_addr_d = dl_addr[14:0];
                    load_din_d  = dl_data;
                end else if (dl_wr) begin
                    overflow_d = 1'b1;
                end
                cart_size_d = size_new;
                if (!dl_active) begin
                    if (size_new <= 16'd8192)       mask_d = 15'h1FFF;
                    else if (size_new <= 16'd16384) mask_d = 15'h3FFF;
                    else                            mask_d = 15'h7FFF;
                    cnt_d = '0;
                    if (size_new[15]) begin
                        state_d = S_HOLD;
                    end else begin
                        state_d     = S_FILL;
                        fill_addr_d = size_new[14:0];
                    end
                end
            end
            S_FILL: begin
                if (dl_active) begin
                    state_d     = S_LOAD;
                    cart_size_d = 16'd0;
                    overflow_d  = 1'b0;
                end else if (fill_we) begin
                    if (fill_addr_q == 15'h7FFF) begin
                        state_d = S_HOLD;
                        cnt_d   = '0;
                    end else begin
                        fill_addr_d = fill_addr_q + 15'd1;
                    end
                end
            end
            default: state_d = S_HOLD;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q     <= S_HOLD;
            cnt_q       <= '0;
            load_we_q   <= 1'b0;
            load_addr_q <= 15'd0;
            load_din_q  <= 8'd0;
            fill_addr_q <= 15'd0;
            cart_size_q <= 16'd0;
            overflow_q  <= 1'b0;
            mask_q      <= 15'h7FFF;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            load_we_q   <= load_we_d;
            load_addr_q <= load_addr_d;
            load_din_q  <= load_din_d;
            fill_addr_q <= fill_addr_d;
            cart_size_q <= cart_size_d;
            overflow_q  <= overflow_d;
            mask_q      <= mask_d;
        end
    end

    assign mem_we     = load_we_q | fill_we;
    assign mem_addr   = fill_we ? fill_addr_q : load_addr_q;
    assign mem_din    = fill_we ? FILL_BYTE : load_din_q;
    assign cart_a_o   = cart_a_i & mask_q;
    assign core_reset = (state_q != S_RUN);
    assign busy       = (state_q != S_RUN);
    assign cart_size  = cart_size_q;
    assign overflow   = overflow_q;

endmodule

// File: doc/cart_load_seq.md
CART_LOAD_SEQ -- requirements
Module: cart_load_seq

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 1024: core-reset stretch after load/fill, in clk_sys cycles.
REQ-002 SHALL have parameter FILL_BYTE, default 8'hFF: value written to cart bytes not loaded.
REQ-003 SHALL have port clk_sys  in  1: single system clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  in  1: asynchronous, active-high reset.
REQ-005 SHALL have port dl_active  in  1: download in progress.
REQ-006 SHALL have port dl_wr  in  1: one-cycle strobe, download byte valid.
REQ-007 SHALL have port dl_addr  in  25: byte address of the download byte.
REQ-008 SHALL have port dl_data  in  8: download byte.
REQ-009 SHALL have port cart_a_i  in  15: console cartridge read address.
REQ-010 SHALL have port cart_a_o  out  15: mirrored read address to cart memory read port.
REQ-011 SHALL have port mem_we  out  1: cart memory write enable.
REQ-012 SHALL have port mem_addr  out  15: cart memory write address.
REQ-013 SHALL have port mem_din  out  8: cart memory write data.
REQ-014 SHALL have port core_reset  out  1: active-high reset to console.
REQ-015 SHALL have port busy  out  1: high whenever state is not RUN.
REQ-016 SHALL have port cart_size  out  16: loaded size in bytes, range 0..32768.
REQ-017 SHALL have port overflow  out  1: a download byte at address >= 32768 was dropped.

Function
REQ-018 SHALL implement states HOLD, RUN, LOAD, FILL.
REQ-019 HOLD SHALL count 0..HOLD_CYCLES-1, then go to RUN.
REQ-020 core_reset SHALL be 1 in HOLD, LOAD and FILL, and 0 in RUN.
REQ-021 RUN SHALL move to LOAD on the first cycle dl_active=1.
REQ-022 On entering LOAD, cart_size and overflow SHALL clear to 0.
REQ-023 In LOAD, dl_wr=1 with dl_addr[24:15]=0 SHALL produce mem_we=1, mem_addr=dl_addr[14:0], mem_din=dl_data on the next cycle (latency 1).
REQ-024 In that case, cart_size SHALL update to max(cart_size, dl_addr[14:0]+1), computed 16-bit so that 32768 is representable.
REQ-025 In LOAD, dl_wr=1 with dl_addr[24:15]!=0 SHALL produce no write and SHALL set overflow=1 (sticky until the next LOAD entry).
REQ-026 In LOAD, the cycle dl_active=0 SHALL:
- go to FILL, starting at address cart_size[14:0], when cart_size<32768;
- go directly to HOLD when cart_size=32768.
REQ-027 A dl_wr coinciding with the dl_active falling cycle SHALL still be written and counted.
REQ-028 In FILL, every cycle SHALL write mem_we=1, mem_din=FILL_BYTE, at an address that increments by 1.
REQ-029 After the write to 0x7FFF, FILL SHALL go to HOLD.
REQ-030 FILL SHALL never wrap past 0x7FFF.
REQ-031 With cart_size=0, FILL SHALL fill the full 0x0000..0x7FFF range (32768 writes).
REQ-032 mem_we SHALL be 0 in HOLD and RUN.
REQ-033 The mirror mask SHALL latch on the LOAD exit cycle:
- 0x1FFF if cart_size<=8192;
- 0x3FFF if cart_size<=16384;
- else 0x7FFF.
REQ-034 cart_a_o SHALL equal cart_a_i AND the mask, combinationally (0 latency).
REQ-035 dl_active rising in FILL or HOLD SHALL abort to LOAD on the next edge, with REQ-022 applied.
REQ-036 dl_active held high SHALL keep the block in LOAD indefinitely.
REQ-037 busy SHALL be 1 in HOLD, LOAD and FILL.

Reset
REQ-038 On reset=1, the block SHALL asynchronously go to HOLD with:
- counter=0, core_reset=1, busy=1;
- mem_we=0, mem_addr=0, mem_din=0;
- cart_size=0, overflow=0, mask=0x7FFF.
REQ-039 Reset asserted mid-LOAD or mid-FILL SHALL abandon the operation, with no further writes.
REQ-040 After reset release, the block SHALL reach RUN HOLD_CYCLES cycles later.

Verification
REQ-041 Power-up: release reset with dl_active=0 -> core_reset=1 for exactly HOLD_CYCLES cycles, then core_reset=0 and busy=0.
REQ-042 8 KB load (addresses 0..8191, then dl_active falls):
- 8192 writes with data intact;
- FILL writes 0xFF to 0x2000..0x7FFF (24576 writes);
- cart_size=8192, mask=0x1FFF, so cart_a_i=0x6005 -> cart_a_o=0x0005.
REQ-043 32 KB load plus one byte at 0x8000 -> overflow=1; no FILL state; cart_size=32768; mask=0x7FFF; byte at 0x8000 not written.
REQ-044 Sparse load (single byte at 0x3000) -> cart_size=0x3001, mask=0x3FFF, FILL starts at 0x3001.
REQ-045 dl_active re-asserted mid-FILL -> LOAD on the next cycle, FILL writes stop, cart_size=0, core_reset stays 1.
REQ-046 reset pulsed mid-LOAD -> mem_we=0 immediately; state HOLD; cart_size=0.
